dcache_line_reader: RTL and testbench
=====================================

Name: dcache_line_reader

Overview:
- Direct-mapped, write-through, no-write-allocate data cache between the CPU load/store path and the data memory.
- On a read miss it presents a 64-byte-aligned line address to the data memory, waits a fixed latency, then captures all 16 memory words (memory outputs data1..data16) into one line.
- Stores are forwarded one-for-one to the memory's memWrite/sb write port. The cache line is also updated on a hit.
- Produces a stall to the pipeline while a miss or store is in progress.

Parameters:
- LINES, 16, number of cache lines (power of 2); index width = log2(LINES).
- FILL_LATENCY, 2, cycles mem_addr is held before mem_line is sampled.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- cpu_addr  in  32  byte address of the load/store
- cpu_wdata  in  32  store data (byte in [7:0] for sb)
- cpu_read  in  1  load request
- cpu_write  in  1  store request
- cpu_sb  in  1  store is a byte store (with cpu_write)
- cpu_rdata  out  32  load data
- stall  out  1  pipeline must hold the current request
- mem_addr  out  32  address to data memory (line base on fill, cpu_addr on store)
- mem_wdata  out  32  store data to memory
- mem_write  out  1  memory write strobe
- mem_sb  out  1  byte-store select to memory
- mem_line  in  512  16 words from memory; word k (memory output data(k+1)) occupies bits [32k+31:32k]

Behaviour:
- Address split: offset [5:0], word select [5:2], index [6+log2(LINES)-1:6], tag = remaining upper bits. Word reads ignore addr[1:0].
- Storage: per line one valid bit, one tag and 16x32 data. Data contents are not reset.
- Reset (asynchronous, any state): all valid bits = 0, state = IDLE, stall = 0, mem_write = 0, mem_sb = 0, mem_addr = 0, mem_wdata = 0, cpu_rdata = 0, fill counter = 0. A reset during FILL discards the partial fill; the line stays invalid.
- States: IDLE, FILL, WRITE.
- IDLE, no request: stall = 0, mem_write = 0.
- IDLE, cpu_read hit (valid and tag match): cpu_rdata = selected word combinationally, stall = 0, zero added latency, no memory access.
- IDLE, cpu_read miss: stall = 1 in the same cycle. Latch the line base {tag,index,6'b0} into mem_addr and go to FILL with counter = 0.
- FILL:
  - stall = 1 and mem_addr held stable; the counter increments every cycle.
  - When counter == FILL_LATENCY, write mem_line into the line, set valid, write the tag, then go to IDLE.
  - The still-asserted cpu_read then hits. Total miss penalty = FILL_LATENCY+2 stalled cycles.
- IDLE, cpu_write (has priority if cpu_read is also high): stall = 1 this cycle. Latch cpu_addr, cpu_wdata and cpu_sb, then go to WRITE.
- WRITE: exactly one cycle with the following outputs, then return to IDLE:
  - mem_write = 1, mem_addr = latched address, mem_wdata = latched data, mem_sb = latched sb, stall = 0.
  - On a hit, the cached word is updated in the same cycle: whole word, or only byte lane addr[1:0] for sb.
  - On a miss the cache is unchanged (no allocate).
- mem_write is never high outside WRITE. mem_sb is meaningful only while mem_write = 1 and is 0 otherwise.
- A store to a line that is currently being filled cannot occur: the pipeline is stalled during FILL.
- Back-to-back stores: each costs one stall cycle plus one WRITE cycle.
- cpu_rdata outside a read hit holds its last value.

Test Plan:
1. Memory bytes 0..15 preloaded as 01 00 00 00, 02 f0 00 f0, 03 00 00 00, 04 00 00 00. After reset, load 0x0 -> stall = 1 for 4 cycles, mem_addr = 0x0 throughout; then cpu_rdata = 0x00000001 with stall = 0.
2. Immediately load 0x4, then 0xC -> both hit with no stall: 0xF000F002, then 0x00000004; mem_addr unchanged, mem_write = 0.
3. Store word 0xDEADBEEF to 0x8 -> one stall cycle, then one cycle with mem_write = 1, mem_addr = 0x8, mem_sb = 0. A following load 0x8 hits and returns 0xDEADBEEF.
4. Byte store 0x000000AB to 0xD -> mem_sb = 1, mem_addr = 0xD. A following load 0xC hits and returns 0x0000AB04.
5. Load 0x400 (same index 0 as 0x0, LINES = 16) -> miss, fill from mem_addr 0x400. A subsequent load 0x0 misses again and refills.
6. Store to 0x40 with line 1 invalid, then load 0x40 -> the store does not allocate (load misses and fills from memory, returning the stored value). Separately, assert reset two cycles into a FILL -> stall = 0 and state IDLE immediately; a re-issued load misses again.

Source files
------------

// File: rtl/dcache_line_reader_if.sv
// dcache_line_reader_if: CPU load/store and data-memory bus of the line-fill data cache
interface dcache_line_reader_if;
   logic [31:0]  cpu_addr, cpu_wdata, cpu_rdata, mem_addr, mem_wdata;
   logic         cpu_read, cpu_write, cpu_sb, stall, mem_write, mem_sb;
   logic [511:0] mem_line;
   modport master (
      output cpu_addr, cpu_wdata, cpu_read, cpu_write, cpu_sb, mem_line,
      input  cpu_rdata, stall, mem_addr, mem_wdata, mem_write, mem_sb
   );
   modport slave (
      input  cpu_addr, cpu_wdata, cpu_read, cpu_write, cpu_sb, mem_line,
      output cpu_rdata, stall, mem_addr, mem_wdata, mem_write, mem_sb
   );
endinterface

// File: rtl/dcache_line_reader.sv
// dcache_line_reader: direct-mapped write-through no-write-allocate data cache with whole-line fill
module dcache_line_reader #(
   parameter int LINES        = 16,
   parameter int FILL_LATENCY = 2
) (
   input logic                 clk,
   input logic                 reset,
   dcache_line_reader_if.slave bus
);
   localparam int IW = $clog2(LINES);
   localparam int TW = 26 - IW;
   localparam int CW = $clog2(FILL_LATENCY + 1) < 1 ? 1 : $clog2(FILL_LATENCY + 1);
   typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;
   state_t         state_q;
   logic [CW-1:0]  cnt_q;
   logic [LINES-1:0] valid_q;
   logic [TW-1:0]  tag_q [LINES];
   logic [31:0]    data_q [LINES][16];
   logic [31:0]    rdata_q, mem_addr_q, mem_wdata_q;
   logic           mem_write_q, mem_sb_q;
   logic [IW-1:0]  c_idx, m_idx;
   logic [TW-1:0]  c_tag, m_tag;
   logic           idle, c_hit, m_hit, rd_hit, fill_done;
   logic [31:0]    c_word, m_word, m_new;
   // lookup of the CPU address and of the latched memory address, plus store merge
   always_comb begin
      c_idx     = bus.cpu_addr[6 +: IW];
      c_tag     = bus.cpu_addr[31 -: TW];
      m_idx     = mem_addr_q[6 +: IW];
      m_tag     = mem_addr_q[31 -: TW];
      idle      = state_q == IDLE;
      c_hit     = valid_q[c_idx] && tag_q[c_idx] == c_tag;
      m_hit     = valid_q[m_idx] && tag_q[m_idx] == m_tag;
      rd_hit    = idle && bus.cpu_read && !bus.cpu_write && c_hit;
      fill_done = state_q == FILL && cnt_q == CW'(FILL_LATENCY);
      c_word    = data_q[c_idx][bus.cpu_addr[5:2]];
      m_word    = data_q[m_idx][mem_addr_q[5:2]];
      m_new     = mem_wdata_q;
      if (mem_sb_q) begin
         m_new = m_word;
         m_new[8*mem_addr_q[1:0] +: 8] = mem_wdata_q[7:0];
      end
   end
   assign bus.stall     = !reset && (state_q == FILL || (idle && (bus.cpu_write || (bus.cpu_read && !c_hit))));
   assign bus.cpu_rdata = rd_hit ? c_word : rdata_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.mem_write = mem_write_q;
   assign bus.mem_sb    = mem_sb_q;
   // control FSM: miss fill sequencing, one-cycle store write-through, held load data
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         valid_q     <= '0;
         rdata_q     <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_write_q <= 1'b0;
         mem_sb_q    <= 1'b0;
      end else begin
         if (rd_hit) rdata_q <= c_word;
         if (state_q == WRITE) begin
            state_q     <= IDLE;
            mem_write_q <= 1'b0;
            mem_sb_q    <= 1'b0;
         end else if (state_q == FILL) begin
            cnt_q <= cnt_q + 1'b1;
            if (fill_done) begin
               state_q        <= IDLE;
               valid_q[m_idx] <= 1'b1;
            end
         end else if (bus.cpu_write) begin
            state_q     <= WRITE;
            mem_addr_q  <= bus.cpu_addr;
            mem_wdata_q <= bus.cpu_wdata;
            mem_sb_q    <= bus.cpu_sb;
            mem_write_q <= 1'b1;
         end else if (bus.cpu_read && !c_hit) begin
            state_q    <= FILL;
            cnt_q      <= '0;
            mem_addr_q <= {bus.cpu_addr[31:6], 6'b0};
         end
      end
   // line storage: whole-line fill on completion, word/byte update on a store hit
   always_ff @(posedge clk)
      if (fill_done) begin
         tag_q[m_idx] <= m_tag;
         for (int k = 0; k < 16; k++) data_q[m_idx][k] <= bus.mem_line[32*k +: 32];
      end else if (state_q == WRITE && m_hit) begin
         data_q[m_idx][mem_addr_q[5:2]] <= m_new;
      end
endmodule

// File: tb/tb_dcache_line_reader.sv
// tb_dcache_line_reader: randomized self-checking bench with a transaction-level cache model
module tb_dcache_line_reader;
   localparam int FL = 2;
   logic clk = 1'b0;
   logic reset = 1'b1;
   dcache_line_reader_if bus();
   dcache_line_reader #(.LINES(16), .FILL_LATENCY(FL)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;

   typedef struct {
      logic        st, mw, sb;
      logic [31:0] ma, wd, rd;
   } exp_t;
   exp_t        expq[$];
   int          n_cmp = 0, n_bad = 0;
   logic [31:0] env_mem [logic [29:0]];
   logic [31:0] ref_mem [logic [29:0]];
   bit          res_v [16];
   logic [25:0] res_ln [16];
   logic [31:0] last_ma = 32'h0, last_rd = 32'h0;

   function automatic logic [31:0] init_word(logic [29:0] wa);
      return {wa, 2'b00} * 32'h9E3779B1 + 32'h7F4A7C15;
   endfunction
   function automatic logic [31:0] env_rd(logic [29:0] wa);
      return env_mem.exists(wa) ? env_mem[wa] : init_word(wa);
   endfunction
   function automatic logic [31:0] ref_rd(logic [29:0] wa);
      return ref_mem.exists(wa) ? ref_mem[wa] : init_word(wa);
   endfunction
   function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [1:0] b, logic sb);
      logic [31:0] r;
      r = old;
      if (!sb) return d;
      r[8*b +: 8] = d[7:0];
      return r;
   endfunction

   task automatic check(string name, logic [31:0] got, logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s @%0t: got %h, want %h", name, $time, got, want);
      end
   endtask

   // data memory: applies the DUT's write-through stores and presents the addressed line
   always @(posedge clk)
      if (!reset && bus.mem_write)
         env_mem[bus.mem_addr[31:2]] = merge(env_rd(bus.mem_addr[31:2]), bus.mem_wdata, bus.mem_addr[1:0], bus.mem_sb);
   always @(negedge clk)
      for (int k = 0; k < 16; k++) bus.mem_line[32*k +: 32] = env_rd({bus.mem_addr[31:6], 4'(k)});

   // per-cycle compare of every DUT output against the model's expectation for that cycle
   always @(negedge clk)
      if (expq.size() != 0) begin
         exp_t e;
         e = expq.pop_front();
         check("stall", {31'b0, bus.stall}, {31'b0, e.st});
         check("mem_write", {31'b0, bus.mem_write}, {31'b0, e.mw});
         check("mem_sb", {31'b0, bus.mem_sb}, {31'b0, e.sb});
         check("mem_addr", bus.mem_addr, e.ma);
         check("cpu_rdata", bus.cpu_rdata, e.rd);
         if (e.mw) check("mem_wdata", bus.mem_wdata, e.wd);
      end

   task automatic drive(logic rd, logic wr, logic sb, logic [31:0] a, logic [31:0] d);
      bus.cpu_read  = rd;
      bus.cpu_write = wr;
      bus.cpu_sb    = sb;
      bus.cpu_addr  = a;
      bus.cpu_wdata = d;
   endtask

   task automatic step(exp_t e);
      expq.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cyc();
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      step('{1'b0, 1'b0, 1'b0, last_ma, 32'h0, last_rd});
   endtask

   task automatic do_read(logic [31:0] a, output logic [31:0] got);
      logic [25:0] ln;
      int ix;
      ln = a[31:6];
      ix = int'(a[9:6]);
      drive(1'b1, 1'b0, 1'b0, a, 32'h0);
      if (!(res_v[ix] && res_ln[ix] == ln)) begin
         step('{1'b1, 1'b0, 1'b0, last_ma, 32'h0, last_rd});
         last_ma = {ln, 6'b0};
         for (int i = 0; i < FL + 1; i++) step('{1'b1, 1'b0, 1'b0, last_ma, 32'h0, last_rd});
         res_v[ix]  = 1'b1;
         res_ln[ix] = ln;
      end
      last_rd = ref_rd(a[31:2]);
      expq.push_back('{1'b0, 1'b0, 1'b0, last_ma, 32'h0, last_rd});
      @(negedge clk);
      got = bus.cpu_rdata;
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(logic [31:0] a, logic [31:0] d, logic sb);
      drive(1'b0, 1'b1, sb, a, d);
      step('{1'b1, 1'b0, 1'b0, last_ma, 32'h0, last_rd});
      last_ma = a;
      step('{1'b0, 1'b1, sb, a, d, last_rd});
      ref_mem[a[31:2]] = merge(ref_rd(a[31:2]), d, a[1:0], sb);
   endtask

   initial begin
      logic [31:0] v, a;
      logic [21:0] tg;
      int op;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      env_mem[0] = 32'h00000001; env_mem[1] = 32'hF000F002; env_mem[2] = 32'h00000003; env_mem[3] = 32'h00000004;
      ref_mem[0] = 32'h00000001; ref_mem[1] = 32'hF000F002; ref_mem[2] = 32'h00000003; ref_mem[3] = 32'h00000004;
      @(negedge clk);
      check("reset stall", {31'b0, bus.stall}, 32'h0);
      check("reset mem_write", {31'b0, bus.mem_write}, 32'h0);
      check("reset mem_sb", {31'b0, bus.mem_sb}, 32'h0);
      check("reset mem_addr", bus.mem_addr, 32'h0);
      check("reset cpu_rdata", bus.cpu_rdata, 32'h0);
      @(posedge clk);
      #1 reset = 1'b0;
      do_read(32'h0, v);  check("load 0x0 after fill", v, 32'h00000001);
      do_read(32'h4, v);  check("load 0x4 hit", v, 32'hF000F002);
      do_read(32'hC, v);  check("load 0xC hit", v, 32'h00000004);
      do_write(32'h8, 32'hDEADBEEF, 1'b0);
      do_read(32'h8, v);  check("load 0x8 after sw", v, 32'hDEADBEEF);
      do_write(32'hD, 32'h000000AB, 1'b1);
      do_read(32'hC, v);  check("load 0xC after sb", v, 32'h0000AB04);
      do_read(32'h400, v);
      do_read(32'h0, v);  check("load 0x0 refill", v, 32'h00000001);
      do_write(32'h40, 32'h12345678, 1'b0);
      do_write(32'h44, 32'hCAFEF00D, 1'b0);
      do_read(32'h40, v); check("load 0x40 no-allocate", v, 32'h12345678);
      drive(1'b1, 1'b0, 1'b0, 32'h80, 32'h0);
      step('{1'b1, 1'b0, 1'b0, last_ma, 32'h0, last_rd});
      step('{1'b1, 1'b0, 1'b0, 32'h80, 32'h0, last_rd});
      #2 reset = 1'b1;
      #1;
      check("mid-fill reset stall", {31'b0, bus.stall}, 32'h0);
      check("mid-fill reset mem_addr", bus.mem_addr, 32'h0);
      check("mid-fill reset cpu_rdata", bus.cpu_rdata, 32'h0);
      @(posedge clk);
      #1 reset = 1'b0;
      last_ma = 32'h0;
      last_rd = 32'h0;
      for (int i = 0; i < 16; i++) res_v[i] = 1'b0;
      do_read(32'h80, v);
      do_read(32'h0, v);  check("load 0x0 after reset", v, 32'h00000001);
      repeat (300) begin
         op = int'($urandom_range(0, 2));
         tg = op == 2 ? 22'h2AAAAA : 22'(op);
         a  = {tg, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
         op = int'($urandom_range(0, 9));
         if (op < 5) do_read(a, v);
         else if (op < 8) do_write(a, $urandom, op == 7);
         else idle_cyc();
      end
      idle_cyc();
      idle_cyc();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
